// File: rtl/home_alert_scheduler_if.sv
// Alert scheduler bus: sensor/climate/ack inputs toward the scheduler and the
// presented-alert outputs back to the consumer.
interface home_alert_scheduler_if;
   logic [3:0] sensors;
   logic [5:0] temp;
   logic       ack;
   logic       alert_valid;
   logic [2:0] alert_code;
   logic [5:0] pending;
   logic       heater_on;
   logic       cooler_on;
   logic [2:0] display;

   modport master (
      output sensors, temp, ack,
      input  alert_valid, alert_code, pending, heater_on, cooler_on, display
   );

   modport slave (
      input  sensors, temp, ack,
      output alert_valid, alert_code, pending, heater_on, cooler_on, display
   );
endinterface

// File: rtl/home_alert_scheduler.sv
// Home alert scheduler: latches sensor/climate events, presents them one at a
// time by fixed priority with dwell timeout, ack and fire preemption.
module home_alert_scheduler #(
   parameter int unsigned DWELL   = 8,
   parameter int unsigned TEMP_LO = 10,
   parameter int unsigned TEMP_HI = 21,
   parameter int unsigned HYST    = 2
) (
   input logic             clk,
   input logic             rst,
   home_alert_scheduler_if.slave bus
);
   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_PRESENT = 1'b1;

   localparam logic [2:0] C_FA = 3'd3;
   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
   localparam logic [6:0] LO_SET = 7'(TEMP_LO);
   localparam logic [6:0] LO_REL = 7'(TEMP_LO + HYST);
   localparam logic [6:0] HI_SET = 7'(TEMP_HI);
   localparam logic [6:0] HI_REL = 7'(TEMP_HI - HYST);

   logic [0:0] state_q, state_d;
   logic [2:0] code_q, code_d;
   logic [7:0] cnt_q, cnt_d;
   logic [5:0] pend_q, pend_d;
   logic [3:0] sens_q;
   logic       heat_q, heat_d;
   logic       cool_q, cool_d;

   logic [3:0] evt;
   logic [5:0] set_vec, clr_vec;
   logic [2:0] pick_code;
   logic [6:0] temp7;

   assign temp7 = {1'b0, bus.temp};
   assign evt   = bus.sensors & ~sens_q;

   // Climate demand with hysteresis; heater demand forces the cooler off.
   always_comb begin
      heat_d = heat_q;
      if (temp7 < LO_SET)        heat_d = 1'b1;
      else if (temp7 >= LO_REL)  heat_d = 1'b0;
      cool_d = cool_q;
      if (temp7 > HI_SET)        cool_d = 1'b1;
      else if (temp7 <= HI_REL)  cool_d = 1'b0;
      if (heat_d) cool_d = 1'b0;
   end

   assign set_vec = {cool_d & ~cool_q, heat_d & ~heat_q, evt};

   // Fire outranks the doors; codes are pending bit index + 1.
   always_comb begin
      pick_code = 3'd0;
      if (pend_q[2])      pick_code = 3'd3;
      else if (pend_q[0]) pick_code = 3'd1;
      else if (pend_q[1]) pick_code = 3'd2;
      else if (pend_q[3]) pick_code = 3'd4;
      else if (pend_q[4]) pick_code = 3'd5;
      else if (pend_q[5]) pick_code = 3'd6;
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      clr_vec = '0;
      case (state_q)
         S_IDLE: begin
            if (|pend_q) begin
               state_d = S_PRESENT;
               code_d  = pick_code;
               cnt_d   = 8'd0;
            end
         end
         S_PRESENT: begin
            if (bus.ack) begin
               clr_vec = 6'd1 << (code_q - 3'd1);
               state_d = S_IDLE;
               cnt_d   = 8'd0;
            end else if (pend_q[2] && code_q != C_FA) begin
               code_d = C_FA;
               cnt_d  = 8'd0;
            end else if (cnt_q == DWELL_LAST) begin
               state_d = S_IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A new set on the same edge as the served clear keeps the bit.
   assign pend_d = (pend_q & ~clr_vec) | set_vec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         code_q  <= 3'd0;
         cnt_q   <= 8'd0;
         pend_q  <= '0;
         sens_q  <= '0;
         heat_q  <= 1'b0;
         cool_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         sens_q  <= bus.sensors;
         heat_q  <= heat_d;
         cool_q  <= cool_d;
      end
   end

   assign bus.alert_valid = (state_q == S_PRESENT);
   assign bus.alert_code  = (state_q == S_PRESENT) ? code_q : 3'd0;
   assign bus.display     = (state_q == S_PRESENT) ? code_q : 3'd0;
   assign bus.pending     = pend_q;
   assign bus.heater_on   = heat_q;
   assign bus.cooler_on   = cool_q;
endmodule

// File: tb/tb_home_alert_scheduler.sv
// Directed scenarios plus random traffic against a per-edge rule model of the scheduler.
module tb_home_alert_scheduler;
   localparam int DWELL = 8;
   localparam int TLO = 10, THI = 21, HY = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   home_alert_scheduler_if bus ();

   home_alert_scheduler #(.DWELL(DWELL), .TEMP_LO(TLO), .TEMP_HI(THI), .HYST(HY)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model state: which code is on display (0 = none) and for how long
   logic [3:0] m_prev;
   logic [5:0] m_pend;
   logic       m_h, m_c;
   int         m_shown, m_age;
   int         prio [6] = '{3, 1, 2, 4, 5, 6};

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      total++;
      assert (act === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_prev = '0; m_pend = '0; m_h = 1'b0; m_c = 1'b0; m_shown = 0; m_age = 0;
   endtask

   task automatic model_edge(input logic [3:0] s, input int t, input logic a);
      logic [3:0] ev;
      logic [5:0] setv, clrv;
      logic nh, nc;
      ev = s & ~m_prev;
      nh = m_h;
      if (t < TLO) nh = 1'b1; else if (t >= TLO + HY) nh = 1'b0;
      nc = m_c;
      if (t > THI) nc = 1'b1; else if (t <= THI - HY) nc = 1'b0;
      if (nh) nc = 1'b0;
      setv = {nc & ~m_c, nh & ~m_h, ev};
      clrv = '0;
      if (m_shown != 0) begin
         if (a) begin
            clrv[m_shown-1] = 1'b1;
            m_shown = 0;
         end else if (m_pend[2] && m_shown != 3) begin
            m_shown = 3; m_age = 0;
         end else if (m_age == DWELL - 1) begin
            m_shown = 0;
         end else begin
            m_age++;
         end
      end else begin
         for (int i = 0; i < 6; i++)
            if (m_shown == 0 && m_pend[prio[i]-1]) begin
               m_shown = prio[i]; m_age = 0;
            end
      end
      m_pend = (m_pend & ~clrv) | setv;
      m_prev = s; m_h = nh; m_c = nc;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"},   16'(bus.alert_valid), 16'(m_shown != 0));
      chk({tag, ".code"},    16'(bus.alert_code),  16'(m_shown));
      chk({tag, ".display"}, 16'(bus.display),     16'(m_shown));
      chk({tag, ".pending"}, 16'(bus.pending),     16'(m_pend));
      chk({tag, ".heater"},  16'(bus.heater_on),   16'(m_h));
      chk({tag, ".cooler"},  16'(bus.cooler_on),   16'(m_c));
   endtask

   task automatic step(input logic [3:0] s, input int t, input logic a);
      bus.sensors = s; bus.temp = 6'(t); bus.ack = a;
      @(posedge clk);
      model_edge(s, t, a);
      #1;
      check_all("step");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_all("rst_now");
      repeat (2) @(posedge clk);
      #1;
      check_all("rst_hold");
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] vbits;
      logic [3:0]  s;
      int          t;
      int          codes [$];
      bus.sensors = '0; bus.temp = 6'd15; bus.ack = 1'b0;
      model_reset();
      #2;
      check_all("por");
      @(posedge clk); #1;
      do_reset();

      // single FD event, acked two cycles after presentation
      step(4'b0000, 15, 0);
      step(4'b0001, 15, 0);
      chk("fd.pend", 16'(bus.pending), 16'h0001);
      chk("fd.v0",   16'(bus.alert_valid), 16'd0);
      step(4'b0001, 15, 0);
      chk("fd.v1",   16'(bus.alert_valid), 16'd1);
      chk("fd.code", 16'(bus.alert_code), 16'd1);
      step(4'b0001, 15, 0);
      step(4'b0001, 15, 1);
      chk("fd.clr",  16'(bus.pending), 16'h0000);
      chk("fd.v2",   16'(bus.alert_valid), 16'd0);

      // dwell timeout and re-presentation
      step(4'b0000, 15, 0);
      step(4'b0001, 15, 0);
      vbits = '0;
      for (int i = 0; i < 10; i++) begin
         step(4'b0001, 15, 0);
         vbits[i] = bus.alert_valid;
      end
      chk("dwell.seq",  vbits, 16'b10_1111_1111);
      chk("dwell.code", 16'(bus.alert_code), 16'd1);

      // all four sensors at once, ack held
      do_reset();
      step(4'b0000, 15, 1);
      for (int i = 0; i < 10; i++) begin
         step(4'b1111, 15, 1);
         if (bus.alert_valid) codes.push_back(int'(bus.alert_code));
      end
      chk("all.n", 16'(codes.size()), 16'd4);
      if (codes.size() == 4) begin
         chk("all.c0", 16'(codes[0]), 16'd3);
         chk("all.c1", 16'(codes[1]), 16'd1);
         chk("all.c2", 16'(codes[2]), 16'd2);
         chk("all.c3", 16'(codes[3]), 16'd4);
      end
      chk("all.pend", 16'(bus.pending), 16'h0000);

      // fire preempts a presented FD
      do_reset();
      step(4'b0000, 15, 0);
      step(4'b0001, 15, 0);
      step(4'b0001, 15, 0);
      step(4'b0101, 15, 0);
      chk("pre.still_fd", 16'(bus.alert_code), 16'd1);
      step(4'b0101, 15, 0);
      chk("pre.fa",   16'(bus.alert_code), 16'd3);
      chk("pre.keep", 16'(bus.pending[0]), 16'd1);
      step(4'b0101, 15, 1);
      step(4'b0101, 15, 0);
      chk("pre.fd_back", 16'(bus.alert_code), 16'd1);
      step(4'b0101, 15, 1);
      chk("pre.pend", 16'(bus.pending), 16'h0000);

      // climate hysteresis
      do_reset();
      step(4'b0000, 15, 0);
      step(4'b0000, 9, 0);
      chk("clim.h9",  16'(bus.heater_on), 16'd1);
      chk("clim.p4",  16'(bus.pending[4]), 16'd1);
      step(4'b0000, 11, 0);
      chk("clim.h11", 16'(bus.heater_on), 16'd1);
      step(4'b0000, 12, 0);
      chk("clim.h12", 16'(bus.heater_on), 16'd0);
      step(4'b0000, 23, 0);
      chk("clim.c23", 16'(bus.cooler_on), 16'd1);
      chk("clim.p5",  16'(bus.pending[5]), 16'd1);
      step(4'b0000, 19, 0);
      chk("clim.c19", 16'(bus.cooler_on), 16'd0);

      // reset mid-presentation with fire held high
      do_reset();
      step(4'b0000, 15, 0);
      step(4'b0100, 15, 0);
      step(4'b0100, 15, 0);
      chk("mid.v", 16'(bus.alert_valid), 16'd1);
      do_reset();
      chk("mid.rst_v", 16'(bus.alert_valid), 16'd0);
      step(4'b0100, 15, 0);
      chk("mid.p2", 16'(bus.pending[2]), 16'd1);
      step(4'b0100, 15, 0);
      chk("mid.fa", 16'(bus.alert_code), 16'd3);

      // random traffic
      s = '0;
      t = 15;
      for (int i = 0; i < 600; i++) begin
         if (i % 150 == 149) do_reset();
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) s[b] = ~s[b];
         if ($urandom_range(0, 9) == 0) t = int'($urandom_range(0, 63));
         else t = int'($urandom_range(6, 25));
         step(s, t, $urandom_range(0, 2) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/home_alert_scheduler.md
HOME_ALERT_SCHEDULER -- requirements
Module: home_alert_scheduler

Interface
REQ-001 Parameter DWELL, default 8: cycles an unacknowledged alert is presented before re-arbitration (legal 2..255).
REQ-002 Parameter TEMP_LO, default 10: heater demand threshold (temp < TEMP_LO).
REQ-003 Parameter TEMP_HI, default 21: cooler demand threshold (temp > TEMP_HI).
REQ-004 Parameter HYST, default 2: hysteresis band for heater/cooler release.
REQ-005 clk  input  1  single system clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 sensors  input  4  bit0 front door, bit1 rear door, bit2 fire, bit3 window; level inputs, synchronous to clk.
REQ-008 temp  input  6  unsigned temperature.
REQ-009 ack  input  1  consumer acknowledges the presented alert.
REQ-010 alert_valid  output  1  an alert is being presented.
REQ-011 alert_code  output  3  0 idle, 1 FD, 2 RD, 3 FA, 4 W, 5 Heater, 6 Cooler.
REQ-012 pending  output  6  latched requests, bit0 FD, bit1 RD, bit2 FA, bit3 W, bit4 Heater, bit5 Cooler.
REQ-013 heater_on, cooler_on  output  1 each  hysteretic climate demand.
REQ-014 display  output  3  equals alert_code while alert_valid, else 0.

Function
REQ-015 Sensor events: a registered copy sens_q; event = sensors & ~sens_q; the matching pending bit is set on the same edge the rising level is first sampled.
REQ-016 heater_on sets when temp < TEMP_LO; clears when temp >= TEMP_LO+HYST; holds otherwise.
REQ-017 cooler_on sets when temp > TEMP_HI; clears when temp <= TEMP_HI-HYST; holds otherwise; heater_on and cooler_on never both 1 (heater set wins, cooler forced 0).
REQ-018 pending[4]/pending[5] set on the rising edge of heater_on/cooler_on respectively.
REQ-019 Fixed priority, highest first: FA, FD, RD, W, Heater, Cooler.
REQ-020 FSM states IDLE, PRESENT.
REQ-021 IDLE: if any pending bit set, latch highest-priority code, load dwell counter 0, go PRESENT; else stay.
REQ-022 PRESENT: alert_valid=1, alert_code held stable; dwell counter increments each cycle.
REQ-023 PRESENT with ack=1: clear the served pending bit, go IDLE (alert_valid 0 next cycle).
REQ-024 PRESENT, no ack, counter = DWELL-1: go IDLE, pending bit retained (re-arbitrated next cycle).
REQ-025 Fire preemption: in PRESENT with code != FA and pending[2] set, next edge switches code to FA, counter reset to 0, preempted bit retained.
REQ-026 Latency: sensor rise sampled at edge N -> pending set after N -> alert_valid=1 after N+1.
REQ-027 ack outside PRESENT ignored; ack and fire preemption same cycle: ack wins, fire served from IDLE next.
REQ-028 Set/clear collision on same bit same edge: set wins, bit remains 1.
REQ-029 Counter width 8 bits; never wraps (bounded by DWELL-1).

Reset
REQ-030 rst=1 forces immediately: state IDLE, pending 0, sens_q 0, heater_on 0, cooler_on 0, counter 0, alert_valid 0, alert_code 0, display 0.
REQ-031 Reset mid-PRESENT drops the alert without ack; sensors already high at release produce events on first edge (sens_q=0).

Verification
REQ-032 temp=15, sensors 0000->0001 at edge N, ack at edge N+3 -> pending=000001 after N, alert_valid=1 code 1 after N+1, after N+3 pending=0, alert_valid=0.
REQ-033 sensors 1111 simultaneous, ack every PRESENT cycle -> codes served 3,1,2,4 in order, pending ends 0.
REQ-034 FD presented, sensors[2] rises -> code switches to 3 next cycle, pending[0] stays 1, FD served after FA ack.
REQ-035 FD presented, no ack, DWELL=8 -> alert_valid high 8 cycles, 1 cycle low, re-presented code 1.
REQ-036 temp 15->9->11->12->23->19 -> heater_on 1 at 9, stays at 11, clears at 12; cooler_on 1 at 23, clears at 19; pending bits 4 then 5 set.
REQ-037 rst pulsed mid-PRESENT with sensors=0100 held -> outputs 0 during rst; after release pending[2]=1 on first edge, code 3 next.
